// File: rtl/pipeline_pkg.sv
// ============================================================================
// pipeline_pkg : opcodes, control-bundle widths and hazard FSM states.
// Revision     : 1.0
// ============================================================================
`default_nettype none

package pipeline_pkg;

  localparam int OPC_BITS = 6;

  localparam logic [OPC_BITS-1:0] RTYPE = 6'b000000;
  localparam logic [OPC_BITS-1:0] LW    = 6'b100011;
  localparam logic [OPC_BITS-1:0] SW    = 6'b101011;
  localparam logic [OPC_BITS-1:0] BEQ   = 6'b000100;
  localparam logic [OPC_BITS-1:0] NOP   = 6'b100000;

  localparam int EX_W = 4;
  localparam int M_W  = 3;
  localparam int WB_W = 2;

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    LOAD_STALL = 2'd1,
    MEM_WAIT   = 2'd2
  } hc_state_t;

  // LW writes rt rather than reading it, so only these read rt as a source.
  function automatic logic uses_rt(input logic [OPC_BITS-1:0] opc);
    case (opc)
      RTYPE, SW, BEQ: uses_rt = 1'b1;
      default:        uses_rt = 1'b0;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/hazard_perf_cnt.sv
// ============================================================================
// hazard_perf_cnt : three saturating event counters (stall, flush, wait).
// Revision        : 1.0
// ============================================================================
`default_nettype none

module hazard_perf_cnt #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall_ev,
  input  logic             flush_ev,
  input  logic             wait_ev,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic [CNT_W-1:0] wait_cnt
);

  logic [2:0]       ev;
  logic [CNT_W-1:0] cnt [3];

  assign ev = {wait_ev, flush_ev, stall_ev};

  for (genvar i = 0; i < 3; i++) begin : g_cnt
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
      cnt_d = cnt_q;
      if (ev[i] && (cnt_q != {CNT_W{1'b1}})) cnt_d = cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) cnt_q <= '0;
      else        cnt_q <= cnt_d;
    end

    assign cnt[i] = cnt_q;
  end

  assign stall_cnt = cnt[0];
  assign flush_cnt = cnt[1];
  assign wait_cnt  = cnt[2];

endmodule

`default_nettype wire

// File: rtl/hazard_control.sv
// ============================================================================
// hazard_control : load-use stall, branch flush and memory-freeze sequencing
//                  for a 5-stage MIPS pipeline. Perf counters with
//                  HAZARD_PERF_CNT_EN.
// Revision       : 1.0
// ============================================================================
`default_nettype none

module hazard_control
  import pipeline_pkg::*;
#(
  parameter int REG_W   = 5,
  parameter int OPC_W   = 6,
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [OPC_W-1:0] id_opcode,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             ex_mem_read,
  input  logic [REG_W-1:0] ex_rt,
  input  logic             mem_branch_taken,
  input  logic             mem_access,
  input  logic             dmem_ready,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             pipe_en,
  output logic             idex_bubble,
  output logic             flush_ifid,
  output logic             flush_idex,
  output logic             flush_exmem,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic [CNT_W-1:0] wait_cnt
);

  localparam int WAIT_W = $clog2(TIMEOUT + 1);

  hc_state_t   state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic        mem_timeout_q, mem_timeout_d;
  logic        hazard, freeze, do_flush, do_stall;

  always_comb begin
    hazard   = ex_mem_read && (ex_rt != '0) &&
               ((ex_rt == id_rs) || (uses_rt(id_opcode) && (ex_rt == id_rt)));
    freeze   = !dmem_ready && (mem_access || (state_q == MEM_WAIT));
    do_flush = mem_branch_taken && !freeze;
    do_stall = hazard && (state_q != LOAD_STALL) && !mem_branch_taken && !freeze;

    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    pipe_en     = 1'b1;
    idex_bubble = 1'b0;
    flush_ifid  = 1'b0;
    flush_idex  = 1'b0;
    flush_exmem = 1'b0;
    state_d     = RUN;

    if (freeze) begin
      pc_write   = 1'b0;
      ifid_write = 1'b0;
      pipe_en    = 1'b0;
      state_d    = MEM_WAIT;
    end else if (do_flush) begin
      flush_ifid  = 1'b1;
      flush_idex  = 1'b1;
      flush_exmem = 1'b1;
    end else if (do_stall) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_bubble = 1'b1;
      state_d     = LOAD_STALL;
    end

    // Wait count saturates at TIMEOUT and clears as soon as the freeze lifts.
    wait_d = '0;
    if (freeze) wait_d = (wait_q == WAIT_W'(TIMEOUT)) ? wait_q : wait_q + WAIT_W'(1);
    mem_timeout_d = mem_timeout_q || (wait_d == WAIT_W'(TIMEOUT));

    // Reset must force safe controls without waiting for a clock edge.
    if (!rst_n) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      pipe_en     = 1'b0;
      idex_bubble = 1'b1;
      flush_ifid  = 1'b0;
      flush_idex  = 1'b0;
      flush_exmem = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= RUN;
      wait_q        <= '0;
      mem_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      wait_q        <= wait_d;
      mem_timeout_q <= mem_timeout_d;
    end
  end

  assign mem_timeout = mem_timeout_q;

`ifdef HAZARD_PERF_CNT_EN
  hazard_perf_cnt #(
    .CNT_W (CNT_W)
  ) u_perf (
    .clk       (clk),
    .rst_n     (rst_n),
    .stall_ev  (do_stall),
    .flush_ev  (do_flush),
    .wait_ev   (freeze),
    .stall_cnt (stall_cnt),
    .flush_cnt (flush_cnt),
    .wait_cnt  (wait_cnt)
  );
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
  assign wait_cnt  = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_hazard_control.sv
// ============================================================================
// tb_hazard_control : directed scoreboard bench for hazard_control.
// Revision          : 1.0
// ============================================================================
`default_nettype none

module tb_hazard_control;
  import pipeline_pkg::*;

`ifdef HAZARD_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  // {pc_write, ifid_write, pipe_en, idex_bubble, flush_ifid, flush_idex, flush_exmem, mem_timeout}
  localparam logic [7:0] NORM  = 8'b1110_0000;
  localparam logic [7:0] STALL = 8'b0011_0000;
  localparam logic [7:0] FRZ   = 8'b0000_0000;
  localparam logic [7:0] FLUSH = 8'b1110_1110;
  localparam logic [7:0] RSTV  = 8'b0001_0000;
  localparam logic [7:0] TO    = 8'b0000_0001;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [5:0]  id_opcode = NOP;
  logic [4:0]  id_rs = 5'd1, id_rt = 5'd2, ex_rt = 5'd0;
  logic        ex_mem_read = 1'b0, mem_branch_taken = 1'b0;
  logic        mem_access = 1'b0, dmem_ready = 1'b1;
  logic        pc_write, ifid_write, pipe_en, idex_bubble;
  logic        flush_ifid, flush_idex, flush_exmem, mem_timeout;
  logic [31:0] stall_cnt, flush_cnt, wait_cnt;
  logic [7:0]  ctrl;

  always #5 clk = ~clk;

  hazard_control #(
    .REG_W(5), .OPC_W(6), .TIMEOUT(64), .CNT_W(32)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .id_opcode(id_opcode), .id_rs(id_rs), .id_rt(id_rt),
    .ex_mem_read(ex_mem_read), .ex_rt(ex_rt),
    .mem_branch_taken(mem_branch_taken), .mem_access(mem_access), .dmem_ready(dmem_ready),
    .pc_write(pc_write), .ifid_write(ifid_write), .pipe_en(pipe_en), .idex_bubble(idex_bubble),
    .flush_ifid(flush_ifid), .flush_idex(flush_idex), .flush_exmem(flush_exmem),
    .mem_timeout(mem_timeout),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .wait_cnt(wait_cnt)
  );

  assign ctrl = {pc_write, ifid_write, pipe_en, idex_bubble,
                 flush_ifid, flush_idex, flush_exmem, mem_timeout};

  typedef struct {
    string       nm;
    logic [7:0]  c;
    logic [31:0] s, f, w;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   passes = 0;

  // Monitor: every cycle with a pending expectation is compared mid-cycle.
  initial begin
    exp_t e;
    logic [95:0] want_cnt;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        checks++;
        if (ctrl === e.c) passes++;
        else $display("FAIL %s ctrl: got %b want %b", e.nm, ctrl, e.c);
        want_cnt = PERF ? {e.s, e.f, e.w} : 96'd0;
        checks++;
        if ({stall_cnt, flush_cnt, wait_cnt} === want_cnt) passes++;
        else $display("FAIL %s counters: got s=%0d f=%0d w=%0d want s=%0d f=%0d w=%0d",
                      e.nm, stall_cnt, flush_cnt, wait_cnt,
                      want_cnt[95:64], want_cnt[63:32], want_cnt[31:0]);
      end
    end
  end

  task automatic step(input string nm, input logic r, input logic [5:0] opc,
                      input logic [4:0] rs, input logic [4:0] rt, input logic mr,
                      input logic [4:0] ert, input logic br, input logic acc,
                      input logic rdy, input logic [7:0] c,
                      input logic [31:0] s, input logic [31:0] f, input logic [31:0] w);
    exp_t e;
    @(posedge clk);
    #1;
    rst_n = r; id_opcode = opc; id_rs = rs; id_rt = rt;
    ex_mem_read = mr; ex_rt = ert; mem_branch_taken = br;
    mem_access = acc; dmem_ready = rdy;
    e.nm = nm; e.c = c; e.s = s; e.f = f; e.w = w;
    q.push_back(e);
  endtask

  task automatic idle(input string nm, input logic [7:0] c,
                      input logic [31:0] s, input logic [31:0] f, input logic [31:0] w);
    step(nm, 1'b1, NOP, 5'd1, 5'd2, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, c, s, f, w);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    step("reset", 1'b0, NOP, 5'd1, 5'd2, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, RSTV, 0, 0, 0);
    idle("run_after_reset", NORM, 0, 0, 0);

    step("loaduse_rs", 1'b1, RTYPE, 5'd8, 5'd2, 1'b1, 5'd8, 1'b0, 1'b0, 1'b1, STALL, 0, 0, 0);
    step("stall_suppressed", 1'b1, RTYPE, 5'd8, 5'd2, 1'b1, 5'd8, 1'b0, 1'b0, 1'b1, NORM, 1, 0, 0);
    idle("after_stall", NORM, 1, 0, 0);
    step("lw_after_lw", 1'b1, LW, 5'd3, 5'd9, 1'b1, 5'd9, 1'b0, 1'b0, 1'b1, NORM, 1, 0, 0);
    step("rt_zero", 1'b1, RTYPE, 5'd0, 5'd0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1, NORM, 1, 0, 0);
    step("loaduse_sw_rt", 1'b1, SW, 5'd1, 5'd7, 1'b1, 5'd7, 1'b0, 1'b0, 1'b1, STALL, 1, 0, 0);
    idle("after_sw_stall", NORM, 2, 0, 0);

    step("branch_over_hazard", 1'b1, RTYPE, 5'd8, 5'd2, 1'b1, 5'd8, 1'b1, 1'b0, 1'b1, FLUSH, 2, 0, 0);
    idle("after_flush", NORM, 2, 1, 0);

    for (int k = 1; k <= 5; k++)
      step("memwait_branch_deferred", 1'b1, NOP, 5'd1, 5'd2, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0,
           FRZ, 2, 1, 32'(k - 1));
    step("memwait_release_flush", 1'b1, NOP, 5'd1, 5'd2, 1'b0, 5'd0, 1'b1, 1'b1, 1'b1, FLUSH, 2, 1, 5);
    idle("after_memwait", NORM, 2, 2, 5);

    step("wait2_a", 1'b1, NOP, 5'd1, 5'd2, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, FRZ, 2, 2, 5);
    step("wait2_b", 1'b1, NOP, 5'd1, 5'd2, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, FRZ, 2, 2, 6);
    step("release_into_stall", 1'b1, RTYPE, 5'd8, 5'd2, 1'b1, 5'd8, 1'b0, 1'b1, 1'b1, STALL, 2, 2, 7);
    idle("after_release_stall", NORM, 3, 2, 7);
    idle("idle_run", NORM, 3, 2, 7);

    for (int k = 1; k <= 70; k++)
      step("timeout_wait", 1'b1, NOP, 5'd1, 5'd2, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0,
           (k > 64) ? (FRZ | TO) : FRZ, 3, 2, 32'(7 + k - 1));
    step("timeout_release", 1'b1, NOP, 5'd1, 5'd2, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, NORM | TO, 3, 2, 77);
    idle("timeout_sticky", NORM | TO, 3, 2, 77);

    for (int k = 0; k < 3; k++)
      step("wait_before_reset", 1'b1, NOP, 5'd1, 5'd2, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0,
           FRZ | TO, 3, 2, 32'(77 + k));
    step("async_reset_midwait", 1'b0, NOP, 5'd1, 5'd2, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, RSTV, 0, 0, 0);
    idle("run_after_async_reset", NORM, 0, 0, 0);
    idle("run_steady", NORM, 0, 0, 0);

    @(negedge clk);
    #1;
    if (q.size() != 0) begin
      checks++;
      $display("FAIL drain: got %0d pending want 0", q.size());
    end
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

`default_nettype wire
